// File: rtl/dmem_responder.sv
// Word-addressed data memory for the MEM stage with a fixed multi-cycle access
// latency, pipeline stall generation and misaligned/out-of-range error flagging.
//
// state | meaning
// IDLE  | waiting for req_i; latches the request on acceptance
// BUSY  | counting down the access latency; access happens when cnt reaches 0
// DONE  | one-cycle completion pulse; a new request is re-sampled in IDLE
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              bad_access;
  logic [AW-1:0]     word_idx;

  logic [31:0] mem [DEPTH];

  // Full 32-bit range compare so upper address bits never alias into the array.
  assign bad_access = (addr_q[1:0] != 2'b00) || ((addr_q >> 2) >= 32'(DEPTH));
  assign word_idx   = addr_q[AW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = BUSY;
          cnt_d   = CNTW'(LATENCY - 1);
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          err_d   = bad_access;
          if (!bad_access) begin
            if (we_q) mem_we  = 1'b1;
            else      rdata_d = mem[word_idx];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; state_q is forced to IDLE asynchronously so no
  // write can fire on an edge seen while reset is held.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[word_idx] <= wdata_q;
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign done_o  = (state_q == DONE);
  assign stall_o = req_i & (state_q != DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an associative-array
// memory model; a second LATENCY=1 instance covers the minimum-latency build.
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 3;
  localparam int DEPTH_B = 16;
  localparam int MAXCYC  = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        done_a, err_a, stall_a, done_b, err_b, stall_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model_mem [int];
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_a (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
    .wdata_i(wdata_a), .rdata_o(rdata_a), .done_o(done_a), .err_o(err_a), .stall_o(stall_a)
  );

  dmem_responder #(.DEPTH(DEPTH_B), .LATENCY(1)) u_b (
    .clk_i(clk), .rst_i(rst_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
    .wdata_i(wdata_b), .rdata_o(rdata_b), .done_o(done_b), .err_o(err_b), .stall_o(stall_b)
  );

  // Reference behaviour: returns the expected error flag and updates the model.
  function automatic bit model_apply(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bit err;
    int unsigned word;
    word = addr / 4;
    err  = (addr % 4 != 0) || (word >= DEPTH);
    if (!err) begin
      if (we) model_mem[int'(word)] = wd;
      else    model_rdata = model_mem.exists(int'(word)) ? model_mem[int'(word)] : 32'hx;
    end
    return err;
  endfunction

  // Runs one request to completion on instance a (sel=0) or b (sel=1).
  task automatic access(input bit sel, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int cycles,
                        output int stalls, output bit one_pulse);
    @(negedge clk);
    if (sel) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else     begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    cycles = 0;
    stalls = 0;
    #1;
    forever begin
      if (sel ? stall_b : stall_a) stalls++;
      if (sel ? done_b : done_a) break;
      if (cycles >= MAXCYC) break;
      @(negedge clk);
      #1;
      cycles++;
    end
    rd = sel ? rdata_b : rdata_a;
    er = sel ? err_b : err_a;
    if (sel) req_b = 1'b0; else req_a = 1'b0;
    @(negedge clk);
    #1;
    one_pulse = !(sel ? done_b : done_a);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({rdata_a, done_a, err_a, stall_a} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_a: got rdata=%h done=%b err=%b stall=%b, want all 0", rdata_a, done_a, err_a, stall_a);
    end
    n_cmp++;
    if ({rdata_b, done_b, err_b, stall_b} !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_b: got rdata=%h done=%b err=%b stall=%b, want all 0", rdata_b, done_b, err_b, stall_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({done_a, err_a, stall_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got done=%b err=%b stall=%b, want 000", done_a, err_a, stall_a);
    end
    model_rdata = '0;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int cyc, st; bit op; bit exp_err;
    exp_err = model_apply(1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, cyc, st, op);
    n_cmp++;
    if (st != LATENCY + 1 || cyc != LATENCY + 1) begin
      n_bad++;
      $display("FAIL store_latency: got stalls=%0d done_at=%0d, want %0d", st, cyc, LATENCY + 1);
    end
    n_cmp++;
    if (er !== exp_err || !op) begin
      n_bad++;
      $display("FAIL store_done: got err=%b single_pulse=%b, want err=%b single_pulse=1", er, op, exp_err);
    end
    exp_err = model_apply(1'b0, 32'h10, 32'h0);
    access(1'b0, 1'b0, 32'h10, 32'h0, rd, er, cyc, st, op);
    n_cmp++;
    if (rd !== model_rdata || er !== exp_err || cyc != LATENCY + 1) begin
      n_bad++;
      $display("FAIL load_0x10: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
               rd, er, cyc, model_rdata, exp_err, LATENCY + 1);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int cyc, st; bit op; bit exp_err;
    logic [31:0] top_addr;
    top_addr = 32'((DEPTH - 1) * 4);
    void'(model_apply(1'b1, top_addr, 32'hCAFE0123));
    access(1'b0, 1'b1, top_addr, 32'hCAFE0123, rd, er, cyc, st, op);
    void'(model_apply(1'b0, top_addr, 32'h0));
    access(1'b0, 1'b0, top_addr, 32'h0, rd, er, cyc, st, op);
    exp_err = model_apply(1'b0, 32'h13, 32'h0);
    access(1'b0, 1'b0, 32'h13, 32'h0, rd, er, cyc, st, op);
    n_cmp++;
    if (er !== exp_err || rd !== model_rdata || !op) begin
      n_bad++;
      $display("FAIL misaligned_load: got err=%b rdata=%h pulse=%b, want err=%b rdata=%h pulse=1",
               er, rd, op, exp_err, model_rdata);
    end
    exp_err = model_apply(1'b1, 32'(DEPTH * 4), 32'h0BAD0BAD);
    access(1'b0, 1'b1, 32'(DEPTH * 4), 32'h0BAD0BAD, rd, er, cyc, st, op);
    n_cmp++;
    if (er !== exp_err || rd !== model_rdata) begin
      n_bad++;
      $display("FAIL oor_store: got err=%b rdata=%h, want err=%b rdata=%h", er, rd, exp_err, model_rdata);
    end
    exp_err = model_apply(1'b0, top_addr, 32'h0);
    access(1'b0, 1'b0, top_addr, 32'h0, rd, er, cyc, st, op);
    n_cmp++;
    if (er !== exp_err || rd !== model_rdata) begin
      n_bad++;
      $display("FAIL top_word_intact: got err=%b rdata=%h, want err=%b rdata=%h", er, rd, exp_err, model_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd1, rd2, exp1, exp2; int cyc, gap; bit idle_ok, done_stall_ok;
    void'(model_apply(1'b1, 32'h40, 32'h11112222));
    void'(model_apply(1'b1, 32'h44, 32'h33334444));
    begin
      logic [31:0] r; logic e; int c, s; bit o;
      access(1'b0, 1'b1, 32'h40, 32'h11112222, r, e, c, s, o);
      access(1'b0, 1'b1, 32'h44, 32'h33334444, r, e, c, s, o);
    end
    void'(model_apply(1'b0, 32'h40, 32'h0)); exp1 = model_rdata;
    void'(model_apply(1'b0, 32'h44, 32'h0)); exp2 = model_rdata;
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h40;
    cyc = 0;
    #1;
    while (!done_a && cyc < MAXCYC) begin @(negedge clk); #1; cyc++; end
    rd1 = rdata_a;
    done_stall_ok = (stall_a === 1'b0);
    addr_a = 32'h44;
    gap = 0; idle_ok = 1'b0;
    do begin
      @(negedge clk); #1; gap++;
      if (gap == 1) idle_ok = (done_a === 1'b0) && (stall_a === 1'b1);
    end while (!done_a && gap < MAXCYC);
    rd2 = rdata_a;
    req_a = 1'b0;
    n_cmp++;
    if (gap != LATENCY + 2 || !idle_ok || !done_stall_ok) begin
      n_bad++;
      $display("FAIL b2b_gap: got gap=%0d idle_ok=%b done_stall_low=%b, want gap=%0d 1 1",
               gap, idle_ok, done_stall_ok, LATENCY + 2);
    end
    n_cmp++;
    if (rd1 !== exp1 || rd2 !== exp2) begin
      n_bad++;
      $display("FAIL b2b_data: got %h %h, want %h %h", rd1, rd2, exp1, exp2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy;
    logic [31:0] rd; logic er; int cyc, st; bit op; bit seen_done;
    void'(model_apply(1'b1, 32'h20, 32'h12345678));
    access(1'b0, 1'b1, 32'h20, 32'h12345678, rd, er, cyc, st, op);
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h5A5A5A5A;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_rdata = '0;
    n_cmp++;
    if ({done_a, err_a, rdata_a} !== 34'd0) begin
      n_bad++;
      $display("FAIL midbusy_reset_outputs: got done=%b err=%b rdata=%h, want 0", done_a, err_a, rdata_a);
    end
    @(negedge clk);
    req_a = 1'b0;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); #1; if (done_a) seen_done = 1'b1; end
    n_cmp++;
    if (seen_done) begin
      n_bad++;
      $display("FAIL midbusy_no_done: got done pulse=1, want 0");
    end
    void'(model_apply(1'b0, 32'h20, 32'h0));
    access(1'b0, 1'b0, 32'h20, 32'h0, rd, er, cyc, st, op);
    n_cmp++;
    if (rd !== model_rdata || er !== 1'b0) begin
      n_bad++;
      $display("FAIL midbusy_prior_data: got rdata=%h err=%b, want %h 0", rd, er, model_rdata);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, addr, wd; logic er; int cyc, st; bit op, we, exp_err; int errs;
    errs = 0;
    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      void'(model_apply(1'b1, 32'(w * 4), wd));
      access(1'b0, 1'b1, 32'(w * 4), wd, rd, er, cyc, st, op);
    end
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      we   = $urandom_range(0, 1);
      wd   = $urandom;
      if (kind == 0)      addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else if (kind == 1) addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
      else if (kind == 2) addr = 32'h8000_0000 | 32'($urandom_range(0, 7) * 4);
      else                addr = 32'($urandom_range(0, 7) * 4);
      exp_err = model_apply(we, addr, wd);
      access(1'b0, we, addr, wd, rd, er, cyc, st, op);
      if (er !== exp_err || rd !== model_rdata || st != LATENCY + 1 || !op) begin
        errs++;
        $display("FAIL random_%0d: addr=%h we=%b got err=%b rdata=%h stalls=%0d pulse=%b, want err=%b rdata=%h stalls=%0d",
                 i, addr, we, er, rd, st, op, exp_err, model_rdata, LATENCY + 1);
      end
    end
    n_cmp++;
    if (errs != 0) begin
      n_bad++;
      $display("FAIL random_total: got %0d bad accesses, want 0", errs);
    end
  endtask

  task automatic test_lat1;
    logic [31:0] rd, addr, wd; logic er; int cyc, st; bit op;
    addr = 32'((DEPTH_B - 1) * 4);
    wd   = $urandom;
    access(1'b1, 1'b1, addr, wd, rd, er, cyc, st, op);
    n_cmp++;
    if (cyc != 2 || er !== 1'b0 || !op) begin
      n_bad++;
      $display("FAIL lat1_store: got done_at=%0d err=%b pulse=%b, want 2 0 1", cyc, er, op);
    end
    access(1'b1, 1'b0, addr, 32'h0, rd, er, cyc, st, op);
    n_cmp++;
    if (cyc != 2 || rd !== wd || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lat1_load: got done_at=%0d rdata=%h err=%b, want 2 %h 0", cyc, rd, er, wd);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    test_lat1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
